// File: rtl/rf_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, decode's allocation port,
// and the register file write port.
interface rf_wb_arbiter_if;
  localparam int unsigned DW = 16;
  localparam int unsigned RW = 4;
  localparam int unsigned NREG = 16;

  logic          a_valid;
  logic [RW-1:0] a_reg;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [RW-1:0] b_reg;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic          alloc_valid;
  logic [RW-1:0] alloc_reg;
  logic          WriteReg;
  logic [RW-1:0] DstReg;
  logic [DW-1:0] DstData;
  logic [NREG-1:0] busy;

  modport slave (
    input  a_valid, a_reg, a_data, b_valid, b_reg, b_data, alloc_valid, alloc_reg,
    output a_ready, b_ready, WriteReg, DstReg, DstData, busy
  );

  modport master (
    output a_valid, a_reg, a_data, b_valid, b_reg, b_data, alloc_valid, alloc_reg,
    input  a_ready, b_ready, WriteReg, DstReg, DstData, busy
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between the ALU (A)
// and load (B) writeback paths, with a per-register busy scoreboard for decode.
module rf_wb_arbiter (
  input  logic           clk,
  input  logic           rst,
  rf_wb_arbiter_if.slave wb
);
  localparam int unsigned DW = 16;
  localparam int unsigned RW = 4;
  localparam int unsigned NREG = 16;

  typedef struct packed {
    logic          valid;
    logic [RW-1:0] rid;
    logic [DW-1:0] data;
  } slot_t;

  typedef enum logic {SRC_A = 1'b0, SRC_B = 1'b1} src_e;

  slot_t           slot_a_q, slot_a_d;
  slot_t           slot_b_q, slot_b_d;
  src_e            last_q, last_d;
  logic            wr_q, wr_d;
  logic [RW-1:0]   dst_q, dst_d;
  logic [DW-1:0]   data_q, data_d;
  logic [NREG-1:0] busy_q, busy_d;

  logic  grant_a_c, grant_b_c;
  logic  a_ready_c, b_ready_c;
  slot_t win_c;

  // On a tie the source that did not win last time gets the port.
  always_comb begin
    grant_a_c = slot_a_q.valid & (~slot_b_q.valid | (last_q == SRC_B));
    grant_b_c = slot_b_q.valid & (~slot_a_q.valid | (last_q == SRC_A));
    a_ready_c = ~slot_a_q.valid | grant_a_c;
    b_ready_c = ~slot_b_q.valid | grant_b_c;
  end

  always_comb begin
    slot_a_d = slot_a_q;
    slot_b_d = slot_b_q;
    last_d   = last_q;
    wr_d     = 1'b0;
    dst_d    = dst_q;
    data_d   = data_q;
    busy_d   = busy_q;
    win_c    = grant_a_c ? slot_a_q : slot_b_q;

    if (grant_a_c) begin
      slot_a_d.valid = 1'b0;
      last_d         = SRC_A;
    end
    if (grant_b_c) begin
      slot_b_d.valid = 1'b0;
      last_d         = SRC_B;
    end

    // A same-cycle handshake refills a slot that is draining.
    if (wb.a_valid && a_ready_c) begin
      slot_a_d = '{valid: 1'b1, rid: wb.a_reg, data: wb.a_data};
    end
    if (wb.b_valid && b_ready_c) begin
      slot_b_d = '{valid: 1'b1, rid: wb.b_reg, data: wb.b_data};
    end

    // R0 entries consume their grant but never reach the register file.
    if ((grant_a_c || grant_b_c) && (win_c.rid != '0)) begin
      wr_d   = 1'b1;
      dst_d  = win_c.rid;
      data_d = win_c.data;
    end

    // A new producer outranks the commit of the previous one.
    for (int r = 1; r < NREG; r++) begin
      if (wb.alloc_valid && (wb.alloc_reg == RW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (wr_d && (dst_d == RW'(r))) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_a_q <= '0;
      slot_b_q <= '0;
      last_q   <= SRC_B;
      wr_q     <= 1'b0;
      dst_q    <= '0;
      data_q   <= '0;
      busy_q   <= '0;
    end else begin
      slot_a_q <= slot_a_d;
      slot_b_q <= slot_b_d;
      last_q   <= last_d;
      wr_q     <= wr_d;
      dst_q    <= dst_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
    end
  end

  assign wb.a_ready  = a_ready_c;
  assign wb.b_ready  = b_ready_c;
  assign wb.WriteReg = wr_q;
  assign wb.DstReg   = dst_q;
  assign wb.DstData  = data_q;
  assign wb.busy     = busy_q;

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Shares the register file's single write port between two writeback sources: A is the ALU path, B is the memory-load path. Each source has one holding slot. Requests are accepted through a valid/ready handshake. A registered round-robin grant drives the register file's write port. A per-register busy scoreboard tells decode which registers have a write in flight, so it can stall on RAW hazards. The block sits between the execute/memory stages and the register file's write inputs.

## Interface
Parameters: none. Widths are fixed: 16-bit data and 16 registers with 4-bit ids.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- a_valid  input  1  source A has a write
- a_reg  input  4  destination register for A
- a_data  input  16  write data for A
- a_ready  output  1  A request accepted this cycle when a_valid & a_ready
- b_valid, b_reg, b_data, b_ready  same as A, for source B
- alloc_valid  input  1  decode issued an instruction with a destination
- alloc_reg  input  4  destination register of that instruction
- WriteReg  output  1  write strobe to the register file
- DstReg  output  4  write register id
- DstData  output  16  write data
- busy  output  16  bit r = 1 while register r has an outstanding producer

## Operation
- Holding slots: slot_a and slot_b, each holding {valid, reg, data}. A handshake loads the slot at the clock edge.
- Ready rule: x_ready = !slot_x.valid | grant_x. The grant is combinational from the slots and last_grant. Back-to-back acceptance is allowed when the slot drains in the same cycle.
- Arbitration, evaluated when at least one slot is valid:
  - Only one slot valid: grant it.
  - Both slots valid: grant the source that is not last_grant.
  - last_grant updates only on a grant. Reset value of last_grant = B, so A wins the first tie.
- Grant effect, at the edge:
  - The granted slot empties, unless it is refilled by a same-cycle handshake.
  - The output register loads {WriteReg=1, DstReg=slot.reg, DstData=slot.data}.
  - With no grant, WriteReg=0. DstReg and DstData hold their previous values.
- R0 is hardwired zero:
  - A granted entry with reg=0 consumes the grant, but WriteReg stays 0.
  - alloc_reg=0 never sets busy. busy[0] is constant 0.
- Scoreboard, per register r, evaluated at each edge:
  - The clear source is a committed write, i.e. WriteReg asserting for r.
  - Set if alloc_valid & alloc_reg==r.
  - Else clear if the clear source fires for r.
  - Else hold.
  - Set wins over a simultaneous clear: the newer producer is outstanding.
- Fairness: while both sources keep a slot full, grants strictly alternate. No source waits more than 1 grant cycle.
- Ordering:
  - Writes from one source commit in acceptance order.
  - Across sources, the order is grant order.
  - Decode must not issue two outstanding producers of the same register from different sources. The scoreboard busy stall guarantees this.

## Timing
- Reset (rst=0, asynchronous):
  - Slots are invalid.
  - WriteReg=0, DstReg=0, DstData=0.
  - busy=16'h0000, last_grant=B.
  - a_ready=b_ready=1 once reset is deasserted.
  - Reset asserted mid-operation discards held entries. No write is issued for them.
- Uncontended latency: handshake at edge N, slot valid during N+1, grant at edge N+1, WriteReg high during cycle N+2 (2 cycles).
- busy clear happens at the same edge that raises WriteReg. The clear is visible in the cycle that write is presented to the register file.
- Contention: the loser's slot stays full and its ready stays 0 until it is granted at the next edge, i.e. 1 extra cycle.
- Sustained throughput is 1 write per cycle total, shared by the two sources.
- WriteReg is a single-cycle pulse per granted entry. Consecutive grants give consecutive pulses with no bubble.

## Test plan
- Single A write:
  - Stimulus: a_valid for 1 cycle with reg=5, data=16'hBEEF, after alloc_reg=5.
  - Required: busy[5]=1 until WriteReg=1, DstReg=5, DstData=BEEF appears 2 cycles after the handshake; busy[5]=0 in that same cycle.
- Tie-breaking:
  - Stimulus: A (reg=3, data=0x1111) and B (reg=4, data=0x2222) both valid in the same cycle, out of reset.
  - Required: A commits first, then B in the next cycle; b_ready=0 for exactly 1 cycle.
- Streaming fairness:
  - Stimulus: both sources stream 8 writes each.
  - Required: DstReg commits alternate A,B,A,B…; 16 WriteReg pulses in 16 consecutive cycles; no source waits more than 1 grant cycle.
- R0 handling:
  - Stimulus: B writes reg=0, data=0xFFFF; alloc_reg=0.
  - Required: b_ready handshake completes, WriteReg stays 0, busy stays 16'h0000.
- Simultaneous set and clear:
  - Stimulus: alloc_reg=7 in the same cycle that a write to r7 commits.
  - Required: busy[7]=1 afterward.
- Reset mid-operation:
  - Stimulus: rst asserted low while both slots are full and busy=16'h00F0.
  - Required: outputs go to 0 immediately without waiting for a clock edge; busy=0; no WriteReg pulse after rst is deasserted.
